// File: rtl/led_pwm_driver.sv
// LED output stage: global PWM brightness, per-LED blink masking and a
// small read/write register window at 0xC1..0xC4 on the shared data bus.
module led_pwm_driver #(
  parameter int PRESCALE   = 64,
  parameter int BLINK_TICK = 1_000_000
) (
  input  logic        CLK,
  input  logic        RESETN,
  inout  wire  [7:0]  BUS_DATA,
  input  logic [7:0]  BUS_ADDR,
  input  logic        BUS_WE,
  input  logic [15:0] LED_IN,
  output logic [15:0] LED_OUT
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TK_W = (BLINK_TICK > 1) ? $clog2(BLINK_TICK) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [TK_W-1:0] TK_MAX = TK_W'(BLINK_TICK - 1);

  localparam logic [7:0] ADDR_BRIGHT  = 8'hC1;
  localparam logic [7:0] ADDR_MASK_LO = 8'hC2;
  localparam logic [7:0] ADDR_MASK_HI = 8'hC3;
  localparam logic [7:0] ADDR_PER     = 8'hC4;

  logic [7:0]      bright_q, bright_d;
  logic [7:0]      mask_lo_q, mask_lo_d;
  logic [7:0]      mask_hi_q, mask_hi_d;
  logic [7:0]      blink_per_q, blink_per_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            drive_en_q, drive_en_d;
  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]      per_cnt_q, per_cnt_d;
  logic            phase_q, phase_d;
  logic [15:0]     led_out_q, led_out_d;

  logic            addr_hit;
  logic [7:0]      rd_sel;
  logic            wr_per;
  logic            blink_tick;
  logic            pwm_on;
  logic [15:0]     mask;

  // The bus is only driven with the value latched on the previous edge.
  assign BUS_DATA = drive_en_q ? rd_data_q : 8'hzz;
  assign LED_OUT  = led_out_q;

  // Register window decode: writes, read latch and bus-drive enable.
  always_comb begin
    bright_d    = bright_q;
    mask_lo_d   = mask_lo_q;
    mask_hi_d   = mask_hi_q;
    blink_per_d = blink_per_q;
    rd_sel      = 8'h00;
    addr_hit    = (BUS_ADDR >= ADDR_BRIGHT) && (BUS_ADDR <= ADDR_PER);
    wr_per      = BUS_WE && (BUS_ADDR == ADDR_PER);
    case (BUS_ADDR)
      ADDR_BRIGHT:  rd_sel = bright_q;
      ADDR_MASK_LO: rd_sel = mask_lo_q;
      ADDR_MASK_HI: rd_sel = mask_hi_q;
      ADDR_PER:     rd_sel = blink_per_q;
      default:      rd_sel = 8'h00;
    endcase
    if (BUS_WE) begin
      case (BUS_ADDR)
        ADDR_BRIGHT:  bright_d    = BUS_DATA;
        ADDR_MASK_LO: mask_lo_d   = BUS_DATA;
        ADDR_MASK_HI: mask_hi_d   = BUS_DATA;
        ADDR_PER:     blink_per_d = BUS_DATA;
        default:      ;
      endcase
    end
    drive_en_d = !BUS_WE && addr_hit;
    rd_data_d  = drive_en_d ? rd_sel : rd_data_q;
  end

  // PWM prescaler and free-running 8-bit compare counter.
  always_comb begin
    ps_cnt_d  = ps_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    if (ps_cnt_q == PS_MAX) begin
      ps_cnt_d  = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      ps_cnt_d  = ps_cnt_q + PS_W'(1);
    end
    pwm_on = (bright_q == 8'hFF) || (pwm_cnt_q < bright_q);
  end

  // Blink tick/period counters; a period write restarts the pattern lit.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    per_cnt_d  = per_cnt_q;
    phase_d    = phase_q;
    blink_tick = 1'b0;
    if (wr_per || (blink_per_q == 8'h00)) begin
      tick_cnt_d = '0;
      per_cnt_d  = 8'h00;
      phase_d    = 1'b1;
    end else begin
      if (tick_cnt_q == TK_MAX) begin
        tick_cnt_d = '0;
        blink_tick = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TK_W'(1);
      end
      if (blink_tick) begin
        if (per_cnt_q == (blink_per_q - 8'd1)) begin
          per_cnt_d = 8'h00;
          phase_d   = ~phase_q;
        end else begin
          per_cnt_d = per_cnt_q + 8'd1;
        end
      end
    end
  end

  // Output gating: logical state AND brightness AND (unmasked OR lit phase).
  always_comb begin
    mask      = {mask_hi_q, mask_lo_q};
    led_out_d = LED_IN & {16{pwm_on}} & (~mask | {16{phase_q}});
  end

  // All state, cleared asynchronously so the pins go dark at once.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      bright_q    <= 8'hFF;
      mask_lo_q   <= 8'h00;
      mask_hi_q   <= 8'h00;
      blink_per_q <= 8'h00;
      rd_data_q   <= 8'h00;
      drive_en_q  <= 1'b0;
      ps_cnt_q    <= '0;
      pwm_cnt_q   <= 8'h00;
      tick_cnt_q  <= '0;
      per_cnt_q   <= 8'h00;
      phase_q     <= 1'b1;
      led_out_q   <= 16'h0000;
    end else begin
      bright_q    <= bright_d;
      mask_lo_q   <= mask_lo_d;
      mask_hi_q   <= mask_hi_d;
      blink_per_q <= blink_per_d;
      rd_data_q   <= rd_data_d;
      drive_en_q  <= drive_en_d;
      ps_cnt_q    <= ps_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      per_cnt_q   <= per_cnt_d;
      phase_q     <= phase_d;
      led_out_q   <= led_out_d;
    end
  end

endmodule
